// File: rtl/serial_adder.sv
// serial_adder -- digit-serial adder/subtractor.
//
// Adds two WIDTH-bit operands DIGIT bits per clock, LSB digit first, through a
// DIGIT-bit ripple full-adder chain. An operation takes N = WIDTH/DIGIT RUN
// cycles. Results are loaded into the output registers only on the last RUN
// edge, so partial sums never appear on F.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits added per clock; WIDTH must be a multiple of DIGIT
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request to begin an operation (accepted in IDLE or DONE)
//   A, B       operands, sampled only at the accepting edge
//   C0         carry-in
//   SUB        0: A+B+C0   1: A+~B+(C0^1)
//   F          registered result (mod 2^WIDTH)
//   C1         registered carry-out of the MSB (in SUB mode 1 = no borrow)
//   V          registered signed overflow (carry into MSB ^ carry out of MSB)
//   busy       high while in RUN
//   done       one-cycle pulse (DONE state) marking new F/C1/V
//   dbg_state  current FSM state encoding (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is a level sampled at each rising edge; it is accepted
// only when busy is low, and the accepted operation's result is announced
// by done exactly N edges later. start seen while busy is dropped.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             SUB,
  output logic [WIDTH-1:0] F,
  output logic             C1,
  output logic             V,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             c1_q, c1_d;
  logic             v_q, v_d;

  // Ripple chain over the current low digit of the shifting operands.
  // chain[i] is the carry into bit i of the digit; chain[0] is the running carry.
  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] digit_sum;

  always_comb begin
    chain     = '0;
    digit_sum = '0;
    chain[0]  = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      digit_sum[i] = a_q[i] ^ b_q[i] ^ chain[i];
      chain[i+1]   = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    c1_d    = c1_q;
    v_d     = v_q;

    case (state_q)
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters at the top; after N shifts it has reached bit 0.
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
        carry_d = chain[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          f_d     = sum_d;
          c1_d    = chain[DIGIT];
          // On the last digit chain[DIGIT-1] is the carry into the MSB.
          v_d     = chain[DIGIT] ^ chain[DIGIT-1];
        end
      end
      default: begin  // S_IDLE, S_DONE
        if (start) begin
          state_d = S_RUN;
          a_d     = A;
          b_d     = SUB ? ~B : B;
          carry_d = C0 ^ SUB;
          cnt_d   = '0;
          sum_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      f_q     <= '0;
      c1_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      c1_q    <= c1_d;
      v_q     <= v_d;
    end
  end

  assign F         = f_q;
  assign C1        = c1_q;
  assign V         = v_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: three instances (DIGIT = 1, 4, 8, WIDTH = 8)
// share one clock and one set of inputs; each test looks at the instance it
// targets. Inputs are driven and outputs sampled on the falling edge.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, c0, sub;
  logic [7:0] a, b;

  logic [2:0][7:0] f_v;
  logic [2:0]      c1_v, v_v, busy_v, done_v;
  logic [2:0][1:0] st_v;

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .C0(c0), .SUB(sub),
    .F(f_v[0]), .C1(c1_v[0]), .V(v_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .dbg_state(st_v[0]));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .C0(c0), .SUB(sub),
    .F(f_v[1]), .C1(c1_v[1]), .V(v_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .dbg_state(st_v[1]));

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .C0(c0), .SUB(sub),
    .F(f_v[2]), .C1(c1_v[2]), .V(v_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .dbg_state(st_v[2]));

  // Driver: pulses start with the given operands, scrambles the inputs right
  // after the accepting edge, and waits (bounded) for done on instance idx.
  // Returns edges from the start edge to done, busy cycles seen, a timeout
  // flag, and whether F stayed unchanged while the operation ran.
  task automatic run_op(input int idx, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic0, input logic isub,
                        output int lat, output int bcnt, output logic to,
                        output logic f_stable);
    logic [7:0] f_before;
    @(negedge clk);
    a = ia; b = ib; c0 = ic0; sub = isub; start = 1'b1;
    f_before = f_v[idx];
    @(negedge clk);
    start = 1'b0; a = ~ia; b = ~ib; c0 = ~ic0; sub = ~isub;
    lat = 0; bcnt = 0; to = 1'b1; f_stable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done_v[idx]) begin
        to = 1'b0;
        break;
      end
      if (busy_v[idx]) bcnt++;
      if (f_v[idx] !== f_before) f_stable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; c0 = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (f_v[0] !== 8'h00) begin n_fail++; $display("FAIL reset_f: got %h expected 00", f_v[0]); end
    n_tests++; if (c1_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset_c1: got %b expected 0", c1_v[0]); end
    n_tests++; if (v_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset_v: got %b expected 0", v_v[0]); end
    n_tests++; if (busy_v !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got %b expected 000", busy_v); end
    n_tests++; if (done_v !== 3'b000) begin n_fail++; $display("FAIL reset_done: got %b expected 000", done_v); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (st_v[0] !== 2'd0) begin n_fail++; $display("FAIL reset_idle_state: got %0d expected 0", st_v[0]); end
  endtask

  // Runs one vector on instance idx and checks everything about it inline.
  task automatic test_vector(input string name, input int idx,
                             input logic [7:0] ia, input logic [7:0] ib,
                             input logic ic0, input logic isub,
                             input int exp_lat, input logic [7:0] exp_f,
                             input logic exp_c1, input logic exp_v);
    int lat, bcnt;
    logic to, fs;
    run_op(idx, ia, ib, ic0, isub, lat, bcnt, to, fs);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: no done within 40 cycles", name); end
    n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
    n_tests++; if (bcnt != exp_lat) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bcnt, exp_lat); end
    n_tests++; if (fs !== 1'b1) begin n_fail++; $display("FAIL %s_f_held: F changed while running", name); end
    n_tests++; if (f_v[idx] !== exp_f) begin n_fail++; $display("FAIL %s_f: got %h expected %h", name, f_v[idx], exp_f); end
    n_tests++; if (c1_v[idx] !== exp_c1) begin n_fail++; $display("FAIL %s_c1: got %b expected %b", name, c1_v[idx], exp_c1); end
    n_tests++; if (v_v[idx] !== exp_v) begin n_fail++; $display("FAIL %s_v: got %b expected %b", name, v_v[idx], exp_v); end
    @(negedge clk);
    n_tests++; if (done_v[idx] !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse: got %b expected 0", name, done_v[idx]); end
    n_tests++; if (f_v[idx] !== exp_f) begin n_fail++; $display("FAIL %s_f_hold: got %h expected %h", name, f_v[idx], exp_f); end
  endtask

  task automatic test_add();
    test_vector("add_ff_01", 0, 8'hFF, 8'h01, 1'b0, 1'b0, 8, 8'h00, 1'b1, 1'b0);
    test_vector("add_7f_01", 0, 8'h7F, 8'h01, 1'b0, 1'b0, 8, 8'h80, 1'b0, 1'b1);
    test_vector("add_80_80", 0, 8'h80, 8'h80, 1'b0, 1'b0, 8, 8'h00, 1'b1, 1'b1);
    test_vector("add_c0",    0, 8'h3C, 8'h42, 1'b1, 1'b0, 8, 8'h7F, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    test_vector("sub_05_07", 0, 8'h05, 8'h07, 1'b0, 1'b1, 8, 8'hFE, 1'b0, 1'b0);
    test_vector("sub_07_05", 0, 8'h07, 8'h05, 1'b0, 1'b1, 8, 8'h02, 1'b1, 1'b0);
    test_vector("sub_80_01", 0, 8'h80, 8'h01, 1'b0, 1'b1, 8, 8'h7F, 1'b1, 1'b1);
  endtask

  task automatic test_digit();
    test_vector("digit4", 1, 8'h0F, 8'h01, 1'b1, 1'b0, 2, 8'h11, 1'b0, 1'b0);
    test_vector("digit8", 2, 8'h0F, 8'h01, 1'b1, 1'b0, 1, 8'h11, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    int lat;
    logic to, extra;
    @(negedge clk);
    a = 8'h10; b = 8'h20; c0 = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done_v[0]) begin to = 1'b0; break; end
      if (lat == 2) begin start = 1'b1; a = 8'h55; b = 8'h66; end
      if (lat == 3) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL ignore_timeout: no done within 40 cycles"); end
    n_tests++; if (lat != 8) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 8", lat); end
    n_tests++; if (f_v[0] !== 8'h30) begin n_fail++; $display("FAIL ignore_f: got %h expected 30", f_v[0]); end
    extra = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy_v[0] || done_v[0]) extra = 1'b1;
    end
    n_tests++; if (extra !== 1'b0) begin n_fail++; $display("FAIL ignore_no_second_op: got activity expected none"); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic to, fs;
    run_op(0, 8'h01, 8'h02, 1'b0, 1'b0, lat, bcnt, to, fs);
    n_tests++; if (f_v[0] !== 8'h03 || to !== 1'b0) begin n_fail++; $display("FAIL b2b_first_f: got %h expected 03", f_v[0]); end
    // Start presented during the DONE cycle.
    a = 8'h03; b = 8'h04; c0 = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hAA; b = 8'hBB;
    n_tests++; if (busy_v[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap: busy got %b expected 1", busy_v[0]); end
    lat = 0; to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done_v[0]) begin to = 1'b0; break; end
      @(negedge clk);
      lat++;
    end
    n_tests++; if (lat != 8 || to !== 1'b0) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    n_tests++; if (f_v[0] !== 8'h07) begin n_fail++; $display("FAIL b2b_second_f: got %h expected 07", f_v[0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic seen_done;
    @(negedge clk);
    a = 8'h12; b = 8'h34; c0 = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_v[0]); end
    n_tests++; if (f_v[0] !== 8'h00) begin n_fail++; $display("FAIL midrst_f: got %h expected 00", f_v[0]); end
    n_tests++; if (c1_v[0] !== 1'b0 || v_v[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got c1=%b v=%b expected 0 0", c1_v[0], v_v[0]); end
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done_v[0]) seen_done = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got done pulse expected none"); end
    test_vector("after_rst", 0, 8'h12, 8'h34, 1'b0, 1'b0, 8, 8'h46, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_digit();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
